// File: rtl/lut_bank_pkg.sv
// Shared types and constants for the double-banked RGB LUT controller.
package lut_bank_pkg;

    localparam int LUT_ADDR_W = 8;
    localparam int LUT_DATA_W = 8;

    localparam logic [1:0] CH_R   = 2'd0;
    localparam logic [1:0] CH_G   = 2'd1;
    localparam logic [1:0] CH_B   = 2'd2;
    localparam logic [1:0] CH_ALL = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Registers a level signal and flags its rising edge for one cycle.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/lut_bank_ctrl.sv
// Double-banked RGB LUT writer with v_sync-aligned bank swap.
// Optional forced swap after a v_sync timeout: LUT_SWAP_TIMEOUT_EN.
module lut_bank_ctrl
    import lut_bank_pkg::*;
#(
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int DATA_W = LUT_DATA_W
`ifdef LUT_SWAP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 2000000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              v_sync_in,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_chan,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              commit_req,
    output logic              commit_busy,
    output logic              lut_we,
    output logic [1:0]        lut_chan,
    output logic              lut_bank,
    output logic [ADDR_W-1:0] lut_addr,
    output logic [DATA_W-1:0] lut_data,
    output logic              active_bank,
    output logic              swap_done,
`ifdef LUT_SWAP_TIMEOUT_EN
    output logic              swap_timeout,
`endif
    output logic              init_done
);

    state_t            state;
    logic [ADDR_W+1:0] cnt;
    logic              vs_rise;
    logic              swap;

    sync_edge_det u_vs_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (v_sync_in),
        .rise  (vs_rise)
    );

`ifdef LUT_SWAP_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (state == ST_PENDING) &&
                     (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign swap    = vs_rise | tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_PENDING && !swap) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign swap = vs_rise;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            cnt         <= '0;
            cfg_ready   <= 1'b0;
            commit_busy <= 1'b0;
            lut_we      <= 1'b0;
            lut_chan    <= 2'd0;
            lut_bank    <= 1'b0;
            lut_addr    <= '0;
            lut_data    <= '0;
            active_bank <= 1'b0;
            swap_done   <= 1'b0;
`ifdef LUT_SWAP_TIMEOUT_EN
            swap_timeout <= 1'b0;
`endif
            init_done   <= 1'b0;
        end else begin
            lut_we    <= 1'b0;
            swap_done <= 1'b0;
`ifdef LUT_SWAP_TIMEOUT_EN
            swap_timeout <= 1'b0;
`endif
            unique case (state)
                ST_INIT: begin
                    // Top bit of cnt marks both banks filled
                    if (cnt[ADDR_W+1]) begin
                        init_done   <= 1'b1;
                        active_bank <= 1'b0;
                        cfg_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        lut_we   <= 1'b1;
                        lut_chan <= CH_ALL;
                        lut_bank <= cnt[ADDR_W];
                        lut_addr <= cnt[ADDR_W-1:0];
                        lut_data <= DATA_W'(cnt[ADDR_W-1:0]);
                        cnt      <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        lut_we   <= 1'b1;
                        lut_chan <= cfg_chan;
                        lut_bank <= ~active_bank;
                        lut_addr <= cfg_addr;
                        lut_data <= cfg_data;
                    end
                    if (commit_req) begin
                        commit_busy <= 1'b1;
                        cfg_ready   <= 1'b0;
                        state       <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (swap) begin
                        active_bank <= ~active_bank;
                        swap_done   <= 1'b1;
`ifdef LUT_SWAP_TIMEOUT_EN
                        swap_timeout <= ~vs_rise;
`endif
                        commit_busy <= 1'b0;
                        cfg_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_bank_ctrl.sv
// Scoreboard bench for lut_bank_ctrl against a cycle-level behavioural model.
module tb_lut_bank_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          v_sync_in = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_chan = 2'd0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          commit_req = 1'b0;
    logic          commit_busy;
    logic          lut_we;
    logic [1:0]    lut_chan;
    logic          lut_bank;
    logic [AW-1:0] lut_addr;
    logic [DW-1:0] lut_data;
    logic          active_bank;
    logic          swap_done;
    logic          init_done;
`ifdef LUT_SWAP_TIMEOUT_EN
    logic          swap_timeout;
`endif

    lut_bank_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .v_sync_in   (v_sync_in),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .commit_req  (commit_req),
        .commit_busy (commit_busy),
        .lut_we      (lut_we),
        .lut_chan    (lut_chan),
        .lut_bank    (lut_bank),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .active_bank (active_bank),
        .swap_done   (swap_done),
`ifdef LUT_SWAP_TIMEOUT_EN
        .swap_timeout(swap_timeout),
`endif
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    chan;
        logic          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t wq[$];
    int  swaps_exp = 0;
    int  errors = 0;
    int  checks = 0;

    // model: 0 = filling, 1 = idle, 2 = commit pending
    int  m_mode = 0;
    int  m_fill = 0;
    bit  m_active = 0;
    bit  m_init = 0;
    bit  m_vsq = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (lut_we) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL lut_write: unexpected write ch=%0d bank=%0d addr=%0h data=%0h",
                             lut_chan, lut_bank, lut_addr, lut_data);
                end else begin
                    e = wq.pop_front();
                    if ({lut_chan, lut_bank, lut_addr, lut_data} !== e) begin
                        errors++;
                        $display("FAIL lut_write: got ch=%0d bank=%0d addr=%0h data=%0h expected ch=%0d bank=%0d addr=%0h data=%0h",
                                 lut_chan, lut_bank, lut_addr, lut_data,
                                 e.chan, e.bank, e.addr, e.data);
                    end
                end
            end
            if (swap_done) begin
                checks++;
                if (swaps_exp == 0) begin
                    errors++;
                    $display("FAIL swap_done: got pulse expected none at %0t", $time);
                end else begin
                    swaps_exp--;
                end
`ifdef LUT_SWAP_TIMEOUT_EN
                chk("swap_timeout", swap_timeout, 0);
`endif
            end
        end
    end

    // One clock: check state left by the previous edge, drive, predict the next edge.
    task automatic step(bit v, bit [1:0] ch, bit [AW-1:0] a,
                        bit [DW-1:0] d, bit cm, bit vs);
        wr_t w;
        chk("cfg_ready", cfg_ready, 32'(m_mode == 1));
        chk("commit_busy", commit_busy, 32'(m_mode == 2));
        chk("active_bank", active_bank, 32'(m_active));
        chk("init_done", init_done, 32'(m_init));
        cfg_valid  = v;
        cfg_chan   = ch;
        cfg_addr   = a;
        cfg_data   = d;
        commit_req = cm;
        v_sync_in  = vs;
        case (m_mode)
            0: begin
                if (m_fill < 2 * N) begin
                    w.chan = 2'd3;
                    w.bank = (m_fill >= N);
                    w.addr = AW'(m_fill % N);
                    w.data = DW'(m_fill % N);
                    wq.push_back(w);
                    m_fill++;
                end else begin
                    m_mode = 1;
                    m_init = 1;
                end
            end
            1: begin
                if (v) begin
                    w.chan = ch;
                    w.bank = !m_active;
                    w.addr = a;
                    w.data = d;
                    wq.push_back(w);
                end
                if (cm) m_mode = 2;
            end
            default: begin
                if (vs && !m_vsq) begin
                    m_active = !m_active;
                    swaps_exp++;
                    m_mode = 1;
                end
            end
        endcase
        m_vsq = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd(int pv, int pc, int pt);
        bit t;
        t = ($urandom_range(99) < pt);
        step($urandom_range(99) < pv, 2'($urandom), AW'($urandom),
             DW'($urandom), $urandom_range(99) < pc, v_sync_in ^ t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_outputs",
            32'({lut_we, lut_chan, lut_bank, lut_addr, lut_data, cfg_ready,
                 commit_busy, active_bank, swap_done, init_done}), 0);
        wq.delete();
        swaps_exp  = 0;
        cfg_valid  = 1'b0;
        commit_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_mode   = 0;
        m_fill   = 0;
        m_active = 0;
        m_init   = 0;
        m_vsq    = 0;
    endtask

    initial begin
        #2;
        do_reset();
        // fill: host traffic must be ignored
        repeat (2 * N + 1) step($urandom_range(1), 2'($urandom),
                                AW'($urandom), DW'($urandom),
                                $urandom_range(1) == 1, 1'b0);
        chk("fill_drained", wq.size(), 0);

        step(1, 2'd1, 8'h10, 8'hAB, 0, 0);
        step(1, 2'd0, 8'h01, 8'h11, 0, 0);
        step(1, 2'd2, 8'h02, 8'h22, 0, 0);
        step(1, 2'd3, 8'hFF, 8'h33, 0, 0);
        step(0, 2'd0, 8'h00, 8'h00, 0, 0);

        // write and commit together, v_sync 100 cycles later
        step(1, 2'd2, 8'h05, 8'h55, 1, 0);
        repeat (100) step(1, 2'd1, AW'($urandom), DW'($urandom), 1, 0);
        step(0, 2'd0, 8'h00, 8'h00, 0, 1);
        step(0, 2'd0, 8'h00, 8'h00, 0, 1);
        step(1, 2'd0, 8'h20, 8'h44, 0, 1);

        // commit while v_sync already high
        step(0, 2'd0, 8'h00, 8'h00, 1, 1);
        repeat (5) step(0, 2'd0, 8'h00, 8'h00, 0, 1);
        repeat (2) step(0, 2'd0, 8'h00, 8'h00, 0, 0);
        repeat (2) step(0, 2'd0, 8'h00, 8'h00, 0, 1);

        // edge coinciding with commit_req is not a swap edge
        step(0, 2'd0, 8'h00, 8'h00, 0, 0);
        step(0, 2'd0, 8'h00, 8'h00, 1, 1);
        repeat (3) step(1, 2'd1, 8'h07, 8'h07, 0, 1);
        step(0, 2'd0, 8'h00, 8'h00, 0, 0);
        step(1, 2'd1, 8'h08, 8'h08, 0, 1);
        step(1, 2'd1, 8'h09, 8'h09, 0, 1);

        repeat (3000) rnd(50, 3, 10);

        // reset while a commit is pending, v_sync held high
        step(0, 2'd0, 8'h00, 8'h00, 1, 1);
        step(0, 2'd0, 8'h00, 8'h00, 1, 1);
        chk("pending_before_reset", commit_busy, 1);
        #3;
        do_reset();
        repeat (2 * N + 1) step(0, 2'd0, 8'h00, 8'h00, 0, 1);
        repeat (500) rnd(60, 4, 15);

        repeat (3) step(0, 2'd0, 8'h00, 8'h00, 0, v_sync_in);
        chk("writes_drained", wq.size(), 0);
        chk("swaps_drained", swaps_exp, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
